// File: rtl/spi_slave_byte_engine_if.sv
// Signal bundle between an SPI master, the byte engine and its upstream hoarder.
// Define SPI_BYTE_COUNT_EN to carry the byte_cnt status output.
interface spi_slave_byte_engine_if #(
  parameter int unsigned SPI_DATA_WIDTH = 8
);
  logic                      sclk;
  logic                      cs_n;
  logic                      mosi;
  logic                      miso;
  logic [SPI_DATA_WIDTH-1:0] data_in_byte;
  logic [SPI_DATA_WIDTH-1:0] data_out_byte;
  logic                      byte_valid;
  logic                      ready;
  logic                      flag_start;
`ifdef SPI_BYTE_COUNT_EN
  logic [7:0]                byte_cnt;

  modport slave (
    input  sclk, cs_n, mosi, data_in_byte,
    output miso, data_out_byte, byte_valid, ready, flag_start, byte_cnt
  );

  modport master (
    output sclk, cs_n, mosi, data_in_byte,
    input  miso, data_out_byte, byte_valid, ready, flag_start, byte_cnt
  );
`else
  modport slave (
    input  sclk, cs_n, mosi, data_in_byte,
    output miso, data_out_byte, byte_valid, ready, flag_start
  );

  modport master (
    output sclk, cs_n, mosi, data_in_byte,
    input  miso, data_out_byte, byte_valid, ready, flag_start
  );
`endif
endinterface

// File: rtl/spi_slave_byte_engine.sv
// SPI mode-0 slave byte engine, MSB first, oversampled by clk (>= 8x sclk).
// Define SPI_BYTE_COUNT_EN to add a saturating per-transaction byte counter (byte_cnt).
module spi_slave_byte_engine #(
  parameter int unsigned SPI_DATA_WIDTH = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input logic                    clk,
  input logic                    rst,
  spi_slave_byte_engine_if.slave bus
);
  localparam int unsigned W    = SPI_DATA_WIDTH;
  localparam int unsigned CntW = $clog2(SPI_DATA_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StReload} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_n_sync_q;
  logic                   sclk_prev_q, cs_n_prev_q;
  logic                   sclk_s, mosi_s, cs_n_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_e         state_q, state_d;
  logic [W-1:0]   tx_shift_q, tx_shift_d;
  logic [W-1:0]   rx_shift_q, rx_shift_d;
  logic [W-1:0]   rx_next;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           byte_valid_q, byte_valid_d;
  logic           ready_q, ready_d;
  logic           flag_start_q, flag_start_d;
  logic           reload_q, reload_d;

  // cs_n chain resets low so a select already held low across reset is not
  // mistaken for a fresh falling edge; the master must deselect first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_n_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s      = cs_n_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign cs_fall     = cs_n_prev_q & ~cs_n_s;
  assign rx_next     = {rx_shift_q[W-2:0], mosi_s};
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      byte_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      flag_start_q <= 1'b0;
      reload_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      byte_valid_q <= byte_valid_d;
      ready_q      <= ready_d;
      flag_start_q <= flag_start_d;
      reload_q     <= reload_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    byte_valid_d = 1'b0;
    ready_d      = ready_q;
    flag_start_d = flag_start_q;
    reload_d     = reload_q;

    unique case (state_q)
      StIdle: begin
        ready_d      = 1'b0;
        flag_start_d = 1'b0;
        if (cs_fall) state_d = StLoad;
      end
      StLoad: begin
        if (cs_n_s) begin
          state_d      = StIdle;
          flag_start_d = 1'b0;
        end else begin
          tx_shift_d   = bus.data_in_byte;
          flag_start_d = 1'b1;
          bit_cnt_d    = '0;
          state_d      = StShift;
        end
      end
      StShift: begin
        if (sclk_rise && bit_cnt_inc == CntW'(W)) begin
          // Completion takes priority over a coincident deselect.
          rx_shift_d   = rx_next;
          data_out_d   = rx_next;
          byte_valid_d = 1'b1;
          ready_d      = 1'b0;
          flag_start_d = 1'b0;
          bit_cnt_d    = '0;
          reload_d     = 1'b0;
          state_d      = cs_n_s ? StIdle : StReload;
        end else if (cs_n_s) begin
          ready_d      = 1'b0;
          flag_start_d = 1'b0;
          bit_cnt_d    = '0;
          state_d      = StIdle;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_inc;
          ready_d    = 1'b1;
        end else if (sclk_fall && bit_cnt_q != '0 && bit_cnt_q < CntW'(W)) begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
      StReload: begin
        if (cs_n_s) begin
          ready_d      = 1'b0;
          flag_start_d = 1'b0;
          bit_cnt_d    = '0;
          state_d      = StIdle;
        end else if (reload_q) begin
          // Second cycle: the hoarder has stepped to its next byte by now.
          tx_shift_d = bus.data_in_byte;
          reload_d   = 1'b0;
          state_d    = StShift;
        end else begin
          reload_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.miso          = (state_q == StIdle) ? 1'b0 : tx_shift_q[W-1];
  assign bus.data_out_byte = data_out_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.ready         = ready_q;
  assign bus.flag_start    = flag_start_q;

`ifdef SPI_BYTE_COUNT_EN
  logic [7:0] byte_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == StLoad) begin
      byte_cnt_q <= '0;
    end else if (byte_valid_q && byte_cnt_q != 8'hFF) begin
      byte_cnt_q <= byte_cnt_q + 8'd1;
    end
  end

  assign bus.byte_cnt = byte_cnt_q;
`endif
endmodule

// File: tb/tb_spi_slave_byte_engine.sv
// Self-checking bench for spi_slave_byte_engine: vector table, hand sequences, random frames.
// Define SPI_BYTE_COUNT_EN to also exercise byte_cnt saturation.
module tb_spi_slave_byte_engine;
  localparam int CLK  = 10;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst;
  always #(CLK/2) clk = ~clk;

  spi_slave_byte_engine_if #(.SPI_DATA_WIDTH(8)) bus ();

  spi_slave_byte_engine #(
    .SPI_DATA_WIDTH(8),
    .SYNC_STAGES   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Hoarder model: presents hoard[idx], steps on each received byte, rewinds while deselected.
  logic [7:0]  hoard [0:7];
  int unsigned hidx = 0;
  assign bus.data_in_byte = hoard[hidx[2:0]];
  always @(posedge clk) begin
    if (bus.cs_n) hidx <= 0;
    else if (bus.byte_valid) hidx <= hidx + 1;
  end

  // Monitor sampled on the inactive edge.
  int         bv_cnt = 0;
  int         rf_cnt = 0;
  logic       ready_prev = 1'b0;
  logic [7:0] rx_log [0:1023];
  always @(negedge clk) begin
    if (bus.byte_valid) begin
      rx_log[bv_cnt[9:0]] = bus.data_out_byte;
      bv_cnt = bv_cnt + 1;
    end
    if (ready_prev && !bus.ready) rf_cnt = rf_cnt + 1;
    ready_prev = bus.ready;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic [7:0] miso_cap;
  logic [7:0] mo_arr [0:7];
  logic [7:0] mi_arr [0:7];

  // Master drives bits [first, last) of mo, MSB first; captures MISO just before each rise.
  task automatic spi_bits(input logic [7:0] mo, input int first, input int last, input bit cs_last);
    for (int i = first; i < last; i++) begin
      bus.mosi = mo[7-i];
      #HALF;
      miso_cap[7-i] = bus.miso;
      bus.sclk = 1'b1;
      if (cs_last && i == last - 1) bus.cs_n = 1'b1;
      #HALF;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic xfer(input int n);
    bus.cs_n = 1'b0;
    #(8*CLK);
    for (int b = 0; b < n; b++) begin
      miso_cap = '0;
      spi_bits(mo_arr[b], 0, 8, 1'b0);
      mi_arr[b] = miso_cap;
    end
    #(8*CLK);
    bus.cs_n = 1'b1;
    #(10*CLK);
  endtask

  typedef struct {
    logic [7:0] mo;
    logic [7:0] hd;
    logic [7:0] exp_rx;
    logic [7:0] exp_mi;
  } vec_t;
  vec_t vecs [0:4];

  initial begin
    int bv0, rf0, n;
    logic [7:0] exp_rx [$];
    logic [7:0] exp_tx [$];

    vecs[0] = '{mo: 8'hA5, hd: 8'h3C, exp_rx: 8'hA5, exp_mi: 8'h3C};
    vecs[1] = '{mo: 8'h00, hd: 8'hFF, exp_rx: 8'h00, exp_mi: 8'hFF};
    vecs[2] = '{mo: 8'hFF, hd: 8'h00, exp_rx: 8'hFF, exp_mi: 8'h00};
    vecs[3] = '{mo: 8'h81, hd: 8'h7E, exp_rx: 8'h81, exp_mi: 8'h7E};
    vecs[4] = '{mo: 8'h5A, hd: 8'hC3, exp_rx: 8'h5A, exp_mi: 8'hC3};
    for (int i = 0; i < 8; i++) hoard[i] = 8'h3C;

    rst = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    #2;
    #(5*CLK);
    chk1("reset miso", bus.miso, 1'b0);
    chk8("reset data_out_byte", bus.data_out_byte, 8'h00);
    chk1("reset byte_valid", bus.byte_valid, 1'b0);
    chk1("reset ready", bus.ready, 1'b0);
    chk1("reset flag_start", bus.flag_start, 1'b0);
    rst = 1'b0;
    #(10*CLK);

    // Single byte 0xA5 against 0x3C, with strobe timing inside the byte.
    bv0 = bv_cnt; rf0 = rf_cnt; miso_cap = '0;
    bus.cs_n = 1'b0;
    #(8*CLK);
    chk1("t1 flag_start after load", bus.flag_start, 1'b1);
    chk1("t1 ready before first edge", bus.ready, 1'b0);
    spi_bits(8'hA5, 0, 4, 1'b0);
    chk1("t1 ready mid byte", bus.ready, 1'b1);
    chk1("t1 flag_start mid byte", bus.flag_start, 1'b1);
    spi_bits(8'hA5, 4, 8, 1'b0);
    #(8*CLK);
    chk8("t1 miso byte", miso_cap, 8'h3C);
    chk8("t1 data_out_byte", bus.data_out_byte, 8'hA5);
    chki("t1 byte_valid pulses", bv_cnt - bv0, 1);
    chki("t1 ready falls", rf_cnt - rf0, 1);
    chk1("t1 ready after byte", bus.ready, 1'b0);
    chk1("t1 flag_start after byte", bus.flag_start, 1'b0);
    bus.cs_n = 1'b1;
    #(10*CLK);

    // Abort after 5 bits of 0xFF.
    bv0 = bv_cnt;
    bus.cs_n = 1'b0;
    #(8*CLK);
    spi_bits(8'hFF, 0, 5, 1'b0);
    bus.cs_n = 1'b1;
    #(4*CLK);
    chk1("t3 ready after abort", bus.ready, 1'b0);
    chk1("t3 flag_start after abort", bus.flag_start, 1'b0);
    chk1("t3 miso idle after abort", bus.miso, 1'b0);
    #(10*CLK);
    chki("t3 no byte_valid", bv_cnt - bv0, 0);
    chk8("t3 data_out_byte kept", bus.data_out_byte, 8'hA5);
    bv0 = bv_cnt; mo_arr[0] = 8'h5A;
    xfer(1);
    chki("t3 next byte_valid", bv_cnt - bv0, 1);
    chk8("t3 next rx", rx_log[bv0[9:0]], 8'h5A);

    // Four-byte frame through the hoarder model.
    hoard[0] = 8'h11; hoard[1] = 8'h22; hoard[2] = 8'h33; hoard[3] = 8'h44;
    mo_arr[0] = 8'hDE; mo_arr[1] = 8'hAD; mo_arr[2] = 8'hBE; mo_arr[3] = 8'hEF;
    bv0 = bv_cnt; rf0 = rf_cnt;
    xfer(4);
    chki("t2 byte_valid pulses", bv_cnt - bv0, 4);
    chki("t2 ready falls", rf_cnt - rf0, 4);
    for (int b = 0; b < 4; b++) begin
      chk8($sformatf("t2 miso byte %0d", b), mi_arr[b], hoard[b]);
      chk8($sformatf("t2 rx byte %0d", b), rx_log[(bv0 + b) % 1024], mo_arr[b]);
    end

    // Vector table of single-byte frames.
    for (int v = 0; v < 5; v++) begin
      hoard[0] = vecs[v].hd;
      mo_arr[0] = vecs[v].mo;
      bv0 = bv_cnt;
      xfer(1);
      chk8($sformatf("vec%0d miso", v), mi_arr[0], vecs[v].exp_mi);
      chk8($sformatf("vec%0d rx", v), rx_log[bv0[9:0]], vecs[v].exp_rx);
      chki($sformatf("vec%0d byte_valid", v), bv_cnt - bv0, 1);
    end

    // Random multi-byte frames against the stream model.
    for (int t = 0; t < 15; t++) begin
      n = int'($urandom_range(1, 4));
      exp_rx.delete();
      exp_tx.delete();
      for (int b = 0; b < n; b++) begin
        mo_arr[b] = 8'($urandom);
        hoard[b]  = 8'($urandom);
        exp_rx.push_back(mo_arr[b]);
        exp_tx.push_back(hoard[b]);
      end
      bv0 = bv_cnt; rf0 = rf_cnt;
      xfer(n);
      chki($sformatf("rnd%0d byte_valid", t), bv_cnt - bv0, n);
      chki($sformatf("rnd%0d ready falls", t), rf_cnt - rf0, n);
      for (int b = 0; b < n; b++) begin
        chk8($sformatf("rnd%0d rx %0d", t, b), rx_log[(bv0 + b) % 1024], exp_rx[b]);
        chk8($sformatf("rnd%0d miso %0d", t, b), mi_arr[b], exp_tx[b]);
      end
    end

    // Deselect coincident with the 8th rising edge of 0x7E.
    bv0 = bv_cnt;
    bus.cs_n = 1'b0;
    #(8*CLK);
    spi_bits(8'h7E, 0, 8, 1'b1);
    #(8*CLK);
    chki("t5 byte_valid", bv_cnt - bv0, 1);
    chk8("t5 data_out_byte", bus.data_out_byte, 8'h7E);
    chk1("t5 ready", bus.ready, 1'b0);
    chk1("t5 miso idle", bus.miso, 1'b0);
    #(10*CLK);

    // Reset mid-byte with cs_n held low.
    bus.cs_n = 1'b0;
    #(8*CLK);
    spi_bits(8'hC3, 0, 4, 1'b0);
    rst = 1'b1;
    #CLK;
    rst = 1'b0;
    #CLK;
    chk8("t4 data_out_byte after rst", bus.data_out_byte, 8'h00);
    chk1("t4 byte_valid after rst", bus.byte_valid, 1'b0);
    chk1("t4 ready after rst", bus.ready, 1'b0);
    chk1("t4 flag_start after rst", bus.flag_start, 1'b0);
    chk1("t4 miso after rst", bus.miso, 1'b0);
    bv0 = bv_cnt;
    spi_bits(8'h33, 0, 8, 1'b0);
    #(8*CLK);
    chki("t4 no capture while still selected", bv_cnt - bv0, 0);
    chk8("t4 data_out_byte held", bus.data_out_byte, 8'h00);
    bus.cs_n = 1'b1;
    #(10*CLK);
    bv0 = bv_cnt; mo_arr[0] = 8'h81;
    xfer(1);
    chki("t4 byte_valid after reselect", bv_cnt - bv0, 1);
    chk8("t4 rx after reselect", rx_log[bv0[9:0]], 8'h81);

`ifdef SPI_BYTE_COUNT_EN
    // 300-byte frame saturates the counter; next select clears it.
    bv0 = bv_cnt;
    bus.cs_n = 1'b0;
    #(8*CLK);
    chk8("t6 byte_cnt at start", bus.byte_cnt, 8'd0);
    for (int b = 0; b < 300; b++) spi_bits(8'($urandom), 0, 8, 1'b0);
    #(8*CLK);
    chki("t6 byte_valid pulses", bv_cnt - bv0, 300);
    chk8("t6 byte_cnt saturated", bus.byte_cnt, 8'd255);
    bus.cs_n = 1'b1;
    #(10*CLK);
    chk8("t6 byte_cnt held while idle", bus.byte_cnt, 8'd255);
    bus.cs_n = 1'b0;
    #(8*CLK);
    chk8("t6 byte_cnt cleared", bus.byte_cnt, 8'd0);
    bus.cs_n = 1'b1;
    #(10*CLK);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_byte_engine.md
Name: spi_slave_byte_engine

Overview:
SPI slave physical byte engine, mode 0 (CPOL=0, CPHA=0), MSB first. Sits directly downstream of the word-to-byte hoarder on the SPI link. Serialises the hoarder's current byte onto MISO and deserialises MOSI into received bytes. Generates the `ready` and `flag_start` strobes that the hoarder uses to step through a frame.

Parameters:
SPI_DATA_WIDTH  8  bits per SPI byte; bit counter width is $clog2(SPI_DATA_WIDTH)+1
SYNC_STAGES  2  flip-flop synchroniser depth on sclk, mosi and cs_n (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sclk  input  1  SPI clock from master, asynchronous to clk
cs_n  input  1  chip select from master, active-low, asynchronous
mosi  input  1  master-out serial data
miso  output  1  slave-out serial data
data_in_byte  input  SPI_DATA_WIDTH  byte to transmit (from hoarder data_out_byte)
data_out_byte  output  SPI_DATA_WIDTH  last fully received byte
byte_valid  output  1  one-clk pulse when data_out_byte updates
ready  output  1  high while a byte is in flight; falling edge means byte complete
flag_start  output  1  high from transaction start until first byte completes

Behaviour:
- Reset and clock:
  - Reset is rst, synchronous, active-high; clock is clk.
  - Reset values: miso=0, data_out_byte=0, byte_valid=0, ready=0, flag_start=0, bit_cnt=0, tx/rx shift registers 0, FSM=IDLE.
- Synchronisers and edge detection:
  - sclk, mosi and cs_n each pass through SYNC_STAGES flops.
  - Edges are detected on synced sclk by comparing with its previous value (one extra flop).
  - Requirement: clk >= 8x sclk frequency. Behaviour is undefined below this.
- FSM:
  - IDLE: miso=0, ready=0, flag_start=0. On synced cs_n falling -> LOAD.
  - LOAD (1 cycle): tx_shift <= data_in_byte; flag_start <= 1; bit_cnt <= 0 -> SHIFT.
  - SHIFT:
    - synced sclk rising edge: rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++; ready <= 1 (holds if already 1).
    - When this rising edge brings bit_cnt to SPI_DATA_WIDTH:
      - data_out_byte <= {rx_shift[W-2:0], mosi_sync}; byte_valid pulses 1 clk.
      - ready <= 0; flag_start <= 0; bit_cnt <= 0 -> RELOAD.
    - synced sclk falling edge with 0 < bit_cnt < SPI_DATA_WIDTH: tx_shift <= tx_shift << 1.
  - RELOAD: wait exactly 2 clk, so the hoarder can decrement its count and present the next byte. Then tx_shift <= data_in_byte -> SHIFT.
    - The falling sclk edge following the last bit does not shift tx_shift.
- miso = tx_shift[SPI_DATA_WIDTH-1] in LOAD/SHIFT/RELOAD; 0 in IDLE.
- Latency:
  - Received byte appears SYNC_STAGES+1 clk after the 8th sclk rising edge at the pin.
  - First MISO bit is valid SYNC_STAGES+2 clk after cs_n falls.
- Boundaries:
  - cs_n rises mid-byte (any state except IDLE): abort. Partial rx discarded; no byte_valid; ready <= 0, flag_start <= 0, bit_cnt <= 0 -> IDLE next clk.
  - cs_n rising in the same clk as the completing rising edge: byte completion wins (byte_valid pulses, data stored), then -> IDLE.
  - sclk edges while cs_n high: ignored.
  - Back-to-back transactions (cs_n high for at least 4 clk): each starts with LOAD and a fresh flag_start.
  - rst mid-transaction: immediate return to the reset state. Re-entry requires a new cs_n falling edge observed after rst deasserts; if cs_n is already low, the engine waits for cs_n high then low.
- data_out_byte holds its value until the next completed byte.

Optional Feature:
SPI_BYTE_COUNT_EN
- Defined: adds output byte_cnt [7:0].
  - Cleared to 0 on rst and in LOAD.
  - Increments on each byte_valid.
  - Saturates at 255.
- Not defined: port absent; no counter logic.

Test Plan:
1. cs_n low, master sends 0xA5 on MOSI. Slave data_in_byte=0x3C throughout -> MISO bits 0,0,1,1,1,1,0,0; data_out_byte=0xA5; byte_valid pulses once; ready rises at first rising edge, falls after 8th; flag_start 1 -> 0 at that point.
2. 4-byte transaction with a hoarder model loaded with 0x11223344 -> MISO stream 0x11,0x22,0x33,0x44; MOSI 0xDE,0xAD,0xBE,0xEF captured in order; exactly 4 byte_valid pulses and 4 ready falling edges.
3. cs_n raised after 5 bits of 0xFF -> no byte_valid; data_out_byte keeps previous 0xA5; ready=0 and FSM=IDLE within SYNC_STAGES+2 clk; next transaction 0x5A is received correctly.
4. rst asserted for 1 clk mid-byte with cs_n held low -> all outputs 0; no capture until cs_n toggles high then low; next byte 0x81 is received correctly.
5. cs_n rise coincident with the 8th sclk rising edge of 0x7E -> byte_valid pulses, data_out_byte=0x7E, then IDLE.
6. With SPI_BYTE_COUNT_EN defined: 300-byte transaction -> byte_cnt reads 255; after a new cs_n fall, byte_cnt=0.
